// File: rtl/cpu_sequencer.sv
// Multicycle CPU control sequencer: one-hot phase bus FETCH/DECODE/EXEC_k/PC_INC with halt and memory fault handling.
// Latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXEC, PC_INC); each mem_rdy-low cycle adds one.
// Backpressure: stalls in FETCH or memory EXEC while mem_rdy is low; en low takes effect only at the PC_INC boundary.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en             run enable, sampled in IDLE and PC_INC
//   func, halt,    execute class, halt flag and memory-access flag from the
//   mem_op         decoder, all sampled in DECODE
//   mem_rdy        memory access complete
//   state          one-hot: [0]IDLE [1]FETCH [2]DECODE [3+k]EXEC_k
//                  [NFUNC+3]PC_INC [NFUNC+4]HALT [NFUNC+5]FAULT
//   mem_req        memory request (FETCH, and EXEC when latched mem_op=1)
//   busy, halted,  status flags
//   fault
//   instr_count    retired instructions, saturating
//
// Build option: define CPU_SEQUENCER_TIMEOUT_EN to enable the MEM_TIMEOUT
// fault. Without it the sequencer waits on mem_rdy forever and FAULT is
// never entered (its state bit and the fault output are constant 0).

module cpu_sequencer #(
    parameter int FUNC_W      = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [FUNC_W-1:0]       func,
    input  logic                    halt,
    input  logic                    mem_op,
    input  logic                    mem_rdy,
    output logic [(2**FUNC_W)+5:0]  state,
    output logic                    mem_req,
    output logic                    busy,
    output logic                    halted,
    output logic                    fault,
    output logic [CNT_W-1:0]        instr_count
);

    localparam int NFUNC    = 2**FUNC_W;
    localparam int B_PC_INC = NFUNC + 3;
    localparam int B_HALT   = NFUNC + 4;
    localparam int B_FAULT  = NFUNC + 5;

    generate
        if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
            $error("cpu_sequencer: MEM_TIMEOUT must be in 1..255");
        end
    endgenerate

    // The EXEC_k bits are not separate FSM states: one EXEC phase plus the
    // latched func selects which bit of the bus is lit.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH,
        PH_DECODE,
        PH_EXEC,
        PH_PC_INC,
        PH_HALT,
        PH_FAULT
    } phase_t;

    phase_t              phase, phase_nxt;
    logic [FUNC_W-1:0]   func_q, func_nxt;
    logic                mem_op_q, mem_op_nxt;
    logic                retire;
    logic                timeout_hit;

`ifdef CPU_SEQUENCER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_wait;

    // wait_cnt counts completed no-ready cycles of the current access; it is
    // zero on entry to every access because it clears whenever no wait is
    // in progress, so FETCH and EXEC each get the full MEM_TIMEOUT budget.
    assign mem_wait    = mem_req && !mem_rdy;
    assign timeout_hit = (wait_cnt == TO_LAST);

    always_comb begin
        wait_nxt = 8'd0;
        if (mem_wait && !timeout_hit) begin
            wait_nxt = wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_IDLE;
            func_q      <= '0;
            mem_op_q    <= 1'b0;
            instr_count <= '0;
        end else begin
            phase    <= phase_nxt;
            func_q   <= func_nxt;
            mem_op_q <= mem_op_nxt;
            if (retire && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        phase_nxt  = phase;
        func_nxt   = func_q;
        mem_op_nxt = mem_op_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        fault      = 1'b0;

        case (phase)
            PH_IDLE: begin
                busy = 1'b0;
                if (en) begin
                    phase_nxt = PH_FETCH;
                end
            end
            PH_FETCH: begin
                mem_req = 1'b1;
                // mem_rdy is tested first so it wins in the timeout cycle
                if (mem_rdy) begin
                    phase_nxt = PH_DECODE;
                end else if (timeout_hit) begin
                    phase_nxt = PH_FAULT;
                end
            end
            PH_DECODE: begin
                func_nxt   = func;
                mem_op_nxt = mem_op;
                phase_nxt  = halt ? PH_HALT : PH_EXEC;
            end
            PH_EXEC: begin
                mem_req = mem_op_q;
                if (!mem_op_q || mem_rdy) begin
                    phase_nxt = PH_PC_INC;
                end else if (timeout_hit) begin
                    phase_nxt = PH_FAULT;
                end
            end
            PH_PC_INC: begin
                retire    = 1'b1;
                phase_nxt = en ? PH_FETCH : PH_IDLE;
            end
            PH_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            PH_FAULT: begin
                busy = 1'b0;
`ifdef CPU_SEQUENCER_TIMEOUT_EN
                fault = 1'b1;
`endif
            end
            default: begin
                phase_nxt = PH_IDLE;
            end
        endcase
    end

    // One-hot bus decoded purely from registered phase and latched func.
    always_comb begin
        state           = '0;
        state[0]        = (phase == PH_IDLE);
        state[1]        = (phase == PH_FETCH);
        state[2]        = (phase == PH_DECODE);
        for (int k = 0; k < NFUNC; k++) begin
            state[3 + k] = (phase == PH_EXEC) && (func_q == FUNC_W'(k));
        end
        state[B_PC_INC] = (phase == PH_PC_INC);
        state[B_HALT]   = (phase == PH_HALT);
`ifdef CPU_SEQUENCER_TIMEOUT_EN
        state[B_FAULT]  = (phase == PH_FAULT);
`else
        state[B_FAULT]  = 1'b0;
`endif
    end

endmodule
